ahb2apb_bridge_param: RTL and testbench

AHB2APB_BRIDGE_PARAM -- requirements
Module: ahb2apb_bridge_param

---
 rtl/ahb2apb_pkg.sv | 35 +++
 rtl/ahb2apb_strb_gen.sv | 45 ++++
 rtl/ahb2apb_bridge_param.sv | 198 +++++++++++++++++++
 tb/tb_ahb2apb_bridge_param.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
// Latency: n/a (types, codes and a constant-evaluable helper only).
// Backpressure: n/a.
package ahb2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb2apb_strb_gen.sv
// Byte-strobe generator and alignment checker for one AHB transfer.
// Latency: purely combinational.
// Backpressure: none.
// Ports: hsize_i (AHB Hsize), addr_lo_i (byte offset within the data bus),
//        strb_o (byte lanes touched), misaligned_o (offset not a multiple of size).
module ahb2apb_strb_gen
    import ahb2apb_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = clog2(STRB_W)
) (
    input  logic [2:0]        hsize_i,
    input  logic [OFF_W-1:0]  addr_lo_i,
    output logic [STRB_W-1:0] strb_o,
    output logic              misaligned_o
);

    always_comb begin
        strb_o       = '0;
        misaligned_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: begin
                strb_o = STRB_W'(1) << addr_lo_i;
            end
            HSIZE_HALF: begin
                strb_o       = STRB_W'(2'b11) << addr_lo_i;
                misaligned_o = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                strb_o       = STRB_W'(4'hF) << addr_lo_i;
                misaligned_o = |addr_lo_i[1:0];
            end
            HSIZE_DWORD: begin
                // Only meaningful on a 64-bit bus; the top rejects it otherwise.
                strb_o       = '1;
                misaligned_o = |addr_lo_i;
            end
            default: begin
                // Larger sizes never reach APB; leave strobes clear.
            end
        endcase
    end

endmodule

// File: rtl/ahb2apb_bridge_param.sv
// AHB-Lite slave to multi-slave APB bridge with error and timeout handling.
// Latency: read 3 cycles address->Hready_out, write 4 cycles (extra WDATA cycle).
// Backpressure: Hready_out low while the APB access is in flight; follows Pready in ACCESS.
// Ports: Hclk/Hreset (sync active-high); AHB side Hsel, Htrans, Haddr, Hwrite, Hsize,
//        Hwdata, Hready_in -> Hready_out, Hresp, Hrdata; APB side Psel (one-hot),
//        Penable, Paddr, Pwrite, Pwdata, Pstrb -> per-slave Prdata, Pready, Pslverr.
module ahb2apb_bridge_param
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                      Hclk,
    input  logic                      Hreset,
    input  logic                      Hsel,
    input  logic [1:0]                Htrans,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic                      Hwrite,
    input  logic [2:0]                Hsize,
    input  logic [DATA_W-1:0]         Hwdata,
    input  logic                      Hready_in,
    output logic                      Hready_out,
    output logic                      Hresp,
    output logic [DATA_W-1:0]         Hrdata,
    output logic [NUM_SLV-1:0]        Psel,
    output logic                      Penable,
    output logic [ADDR_W-1:0]         Paddr,
    output logic                      Pwrite,
    output logic [DATA_W-1:0]         Pwdata,
    output logic [DATA_W/8-1:0]       Pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] Prdata,
    input  logic [NUM_SLV-1:0]        Pready,
    input  logic [NUM_SLV-1:0]        Pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = clog2(STRB_W);
    localparam int SEL_W  = clog2(NUM_SLV);
    localparam int IDX_W  = (SEL_W == 0) ? 1 : SEL_W;
    localparam int CNT_W  = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
    // Last counter value before the timeout fires: ACCESS lasts TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e              state_q;
    logic [NUM_SLV-1:0]  Psel_q;
    logic                Penable_q;
    logic [ADDR_W-1:0]   Paddr_q;
    logic                Pwrite_q;
    logic [DATA_W-1:0]   Pwdata_q;
    logic [STRB_W-1:0]   Pstrb_q;
    logic [IDX_W-1:0]    sel_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [IDX_W-1:0]    idx_d;
    logic [STRB_W-1:0]   strb_d;
    logic                misaligned_d;
    logic                xfer_bad_d;
    logic                accept_d;
    logic                hready_d;
    logic [NUM_SLV-1:0]  psel_new_d;
    logic [NUM_SLV-1:0]  psel_reg_d;
    logic                pready_sel;
    logic                pslverr_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic                timeout_hit;

    generate
        if (SEL_W == 0) begin : g_one_slave
            assign idx_d = '0;
        end else begin : g_idx
            assign idx_d = Haddr[SEL_LSB +: IDX_W];
        end
    endgenerate

    ahb2apb_strb_gen #(
        .DATA_W (DATA_W)
    ) u_strb_gen (
        .hsize_i      (Hsize),
        .addr_lo_i    (Haddr[OFF_W-1:0]),
        .strb_o       (strb_d),
        .misaligned_o (misaligned_d)
    );

    // Decoded-but-unreachable slave, size wider than the bus, or misalignment
    // all bypass APB and go straight to the two-cycle error response.
    assign xfer_bad_d = ({1'b0, idx_d} >= (IDX_W + 1)'(NUM_SLV))
                      | (Hsize > 3'(OFF_W))
                      | misaligned_d;

    assign accept_d = Hsel & ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ))
                    & Hready_in & hready_d;

    assign psel_new_d = NUM_SLV'(1) << idx_d;
    assign psel_reg_d = NUM_SLV'(1) << sel_q;

    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        rdata_sel   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q == IDX_W'(i)) begin
                pready_sel  = Pready[i];
                pslverr_sel = Pslverr[i];
                rdata_sel   = Prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        hready_d = 1'b0;
        case (state_q)
            ST_IDLE:   hready_d = 1'b1;
            ST_ACCESS: hready_d = pready_sel & ~pslverr_sel;
            ST_ERR2:   hready_d = 1'b1;
            default:   hready_d = 1'b0;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= ST_IDLE;
            Psel_q    <= '0;
            Penable_q <= 1'b0;
            Paddr_q   <= '0;
            Pwrite_q  <= 1'b0;
            Pwdata_q  <= '0;
            Pstrb_q   <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_WDATA: begin
                    Pwdata_q <= Hwdata;
                    Psel_q   <= psel_reg_d;
                    state_q  <= ST_SETUP;
                end
                ST_SETUP: begin
                    Penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_sel) begin
                        Psel_q    <= '0;
                        Penable_q <= 1'b0;
                        state_q   <= pslverr_sel ? ST_ERR1 : ST_IDLE;
                    end else if (timeout_hit) begin
                        Psel_q    <= '0;
                        Penable_q <= 1'b0;
                        state_q   <= ST_ERR1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_q <= ST_ERR2;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Acceptance only happens while Hready_out is high (IDLE, ERR2 or a
            // clean ACCESS completion), so it safely overrides the case above and
            // gives back-to-back transfers with no idle cycle.
            if (accept_d) begin
                Paddr_q  <= Haddr;
                Pwrite_q <= Hwrite;
                Pstrb_q  <= Hwrite ? strb_d : '0;
                sel_q    <= idx_d;
                if (xfer_bad_d) begin
                    state_q <= ST_ERR1;
                end else if (Hwrite) begin
                    state_q <= ST_WDATA;
                end else begin
                    Psel_q  <= psel_new_d;
                    state_q <= ST_SETUP;
                end
            end
        end
    end

    assign Hready_out = hready_d;
    assign Hresp      = (state_q == ST_ERR1) | (state_q == ST_ERR2);
    assign Hrdata     = (state_q == ST_ACCESS) ? rdata_sel : '0;
    assign Psel       = Psel_q;
    assign Penable    = Penable_q;
    assign Paddr      = Paddr_q;
    assign Pwrite     = Pwrite_q;
    assign Pwdata     = Pwdata_q;
    assign Pstrb      = Pstrb_q;

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Directed bench for the AHB-to-APB bridge with a response scoreboard.
// Latency: cycle-by-cycle directed steps; outputs sampled 3 time units after each edge.
// Backpressure: APB slaves modelled by driving Pready/Pslverr per step.
module tb_ahb2apb_bridge_param;
    import ahb2apb_pkg::*;

    logic         Hclk = 1'b0;
    logic         Hreset;
    logic         Hsel;
    logic [1:0]   Htrans;
    logic [31:0]  Haddr;
    logic         Hwrite;
    logic [2:0]   Hsize;
    logic [31:0]  Hwdata;
    logic         Hready_in;
    logic         Hready_out;
    logic         Hresp;
    logic [31:0]  Hrdata;
    logic [3:0]   Psel;
    logic         Penable;
    logic [31:0]  Paddr;
    logic         Pwrite;
    logic [31:0]  Pwdata;
    logic [3:0]   Pstrb;
    logic [127:0] Prdata;
    logic [3:0]   Pready;
    logic [3:0]   Pslverr;

    typedef struct packed {
        logic [31:0] rdata;
        logic        resp;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] slv_word [4];

    always #5 Hclk = ~Hclk;

    ahb2apb_bridge_param #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .NUM_SLV (4),
        .SEL_LSB (12),
        .TIMEOUT (8)
    ) dut (
        .Hclk       (Hclk),
        .Hreset     (Hreset),
        .Hsel       (Hsel),
        .Htrans     (Htrans),
        .Haddr      (Haddr),
        .Hwrite     (Hwrite),
        .Hsize      (Hsize),
        .Hwdata     (Hwdata),
        .Hready_in  (Hready_in),
        .Hready_out (Hready_out),
        .Hresp      (Hresp),
        .Hrdata     (Hrdata),
        .Psel       (Psel),
        .Penable    (Penable),
        .Paddr      (Paddr),
        .Pwrite     (Pwrite),
        .Pwdata     (Pwdata),
        .Pstrb      (Pstrb),
        .Prdata     (Prdata),
        .Pready     (Pready),
        .Pslverr    (Pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push(input logic [31:0] rd, input logic resp);
        exp_t e;
        e.rdata = rd;
        e.resp  = resp;
        sb.push_back(e);
    endtask

    // Called on the cycle the bridge completes a transfer (Hready_out=1).
    task automatic sb_check(input string tag);
        exp_t e;
        total++;
        assert (sb.size() > 0) passed++;
        else $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".rdata"}, Hrdata, e.rdata);
            chk({tag, ".resp"},  Hresp,  e.resp);
            chk({tag, ".ready"}, Hready_out, 1'b1);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        Hsel   = 1'b1;
        Htrans = HTRANS_NONSEQ;
        Haddr  = a;
        Hwrite = w;
        Hsize  = sz;
    endtask

    task automatic bus_idle();
        Hsel   = 1'b0;
        Htrans = HTRANS_IDLE;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".psel"},    Psel,       4'b0000);
        chk({tag, ".penable"}, Penable,    1'b0);
        chk({tag, ".paddr"},   Paddr,      32'h0);
        chk({tag, ".pwrite"},  Pwrite,     1'b0);
        chk({tag, ".pwdata"},  Pwdata,     32'h0);
        chk({tag, ".pstrb"},   Pstrb,      4'b0000);
        chk({tag, ".hready"},  Hready_out, 1'b1);
        chk({tag, ".hresp"},   Hresp,      1'b0);
        chk({tag, ".hrdata"},  Hrdata,     32'h0);
    endtask

    initial begin
        int n;
        slv_word[0] = 32'hD0D0_0000;
        slv_word[1] = 32'hD1D1_1111;
        slv_word[2] = 32'hD2D2_2222;
        slv_word[3] = 32'hD3D3_3333;
        for (int i = 0; i < 4; i++) Prdata[i*32 +: 32] = slv_word[i];
        Hreset = 1'b1; Hsel = 1'b0; Htrans = HTRANS_IDLE; Haddr = '0; Hwrite = 1'b0;
        Hsize = HSIZE_WORD; Hwdata = '0; Hready_in = 1'b1; Pready = '0; Pslverr = '0;
        tick(); tick();
        Hreset = 1'b0;
        settle();
        chk_reset("rst");

        // Read slave 2, ready on first ACCESS cycle.
        tick(); addr_phase(32'h0000_2004, 1'b0, HSIZE_WORD); Pready = 4'b0100; settle();
        chk("t1.addr_ready", Hready_out, 1'b1);
        push(slv_word[2], 1'b0);
        tick(); bus_idle(); settle();
        chk("t1.setup_psel", Psel, 4'b0100);
        chk("t1.setup_penable", Penable, 1'b0);
        chk("t1.setup_paddr", Paddr, 32'h0000_2004);
        chk("t1.setup_pwrite", Pwrite, 1'b0);
        chk("t1.setup_pstrb", Pstrb, 4'b0000);
        chk("t1.setup_ready", Hready_out, 1'b0);
        tick(); settle();
        chk("t1.access_psel", Psel, 4'b0100);
        chk("t1.access_penable", Penable, 1'b1);
        sb_check("t1");
        tick(); settle();
        chk("t1.idle_psel", Psel, 4'b0000);
        chk("t1.idle_hrdata", Hrdata, 32'h0);

        // Byte write to slave 1, top lane.
        tick(); addr_phase(32'h0000_1003, 1'b1, HSIZE_BYTE); Pready = 4'b0010; settle();
        push(slv_word[1], 1'b0);
        tick(); Hwdata = 32'hAA00_0000; bus_idle(); settle();
        chk("t2.wdata_ready", Hready_out, 1'b0);
        chk("t2.wdata_psel", Psel, 4'b0000);
        tick(); Hwdata = 32'h1234_5678; settle();
        chk("t2.setup_psel", Psel, 4'b0010);
        chk("t2.setup_penable", Penable, 1'b0);
        chk("t2.setup_pstrb", Pstrb, 4'b1000);
        chk("t2.setup_pwdata", Pwdata, 32'hAA00_0000);
        chk("t2.setup_pwrite", Pwrite, 1'b1);
        chk("t2.setup_ready", Hready_out, 1'b0);
        tick(); settle();
        chk("t2.access_psel", Psel, 4'b0010);
        chk("t2.access_penable", Penable, 1'b1);
        chk("t2.access_pwdata", Pwdata, 32'hAA00_0000);
        chk("t2.access_pstrb", Pstrb, 4'b1000);
        sb_check("t2");
        tick(); settle();
        chk("t2.idle_psel", Psel, 4'b0000);

        // Read with slave error.
        tick(); addr_phase(32'h0000_0008, 1'b0, HSIZE_WORD); Pready = 4'b0001; Pslverr = 4'b0001; settle();
        push(32'h0, 1'b1);
        tick(); bus_idle(); settle();
        chk("t3.setup_psel", Psel, 4'b0001);
        tick(); settle();
        chk("t3.access_ready", Hready_out, 1'b0);
        chk("t3.access_resp", Hresp, 1'b0);
        chk("t3.access_penable", Penable, 1'b1);
        tick(); settle();
        chk("t3.err1_resp", Hresp, 1'b1);
        chk("t3.err1_ready", Hready_out, 1'b0);
        chk("t3.err1_psel", Psel, 4'b0000);
        tick(); settle();
        sb_check("t3");
        tick(); Pslverr = 4'b0000; settle();
        chk("t3.after_resp", Hresp, 1'b0);

        // Timeout with Pready held low on slave 3.
        tick(); addr_phase(32'h0000_3000, 1'b0, HSIZE_WORD); Pready = 4'b0000; settle();
        push(32'h0, 1'b1);
        tick(); bus_idle(); settle();
        chk("t4.setup_psel", Psel, 4'b1000);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick(); settle();
            if (Penable === 1'b1 && Psel === 4'b1000 && Hready_out === 1'b0) n++;
            else break;
        end
        chk("t4.access_cycles", n, 8);
        chk("t4.err1_psel", Psel, 4'b0000);
        chk("t4.err1_penable", Penable, 1'b0);
        chk("t4.err1_resp", Hresp, 1'b1);
        chk("t4.err1_ready", Hready_out, 1'b0);
        tick(); settle();
        sb_check("t4");
        tick(); settle();
        chk("t4.after_resp", Hresp, 1'b0);

        // Misaligned halfword read: straight to error, no APB select.
        tick(); addr_phase(32'h0000_1001, 1'b0, HSIZE_HALF); Pready = 4'b1111; settle();
        push(32'h0, 1'b1);
        tick(); bus_idle(); settle();
        chk("t5.err1_psel", Psel, 4'b0000);
        chk("t5.err1_resp", Hresp, 1'b1);
        chk("t5.err1_ready", Hready_out, 1'b0);
        tick(); settle();
        sb_check("t5");
        tick(); settle();

        // Doubleword write on a 32-bit bus: too wide, error without WDATA.
        tick(); addr_phase(32'h0000_2000, 1'b1, HSIZE_DWORD); settle();
        push(32'h0, 1'b1);
        tick(); bus_idle(); settle();
        chk("t5b.err1_psel", Psel, 4'b0000);
        chk("t5b.err1_resp", Hresp, 1'b1);
        tick(); settle();
        sb_check("t5b");
        tick(); settle();

        // BUSY and unselected transfers are ignored.
        tick(); Hsel = 1'b1; Htrans = HTRANS_BUSY; Haddr = 32'h0000_2004; Hwrite = 1'b0; settle();
        chk("t6.busy_ready", Hready_out, 1'b1);
        chk("t6.busy_resp", Hresp, 1'b0);
        tick(); Hsel = 1'b0; Htrans = HTRANS_NONSEQ; settle();
        chk("t6.busy_psel", Psel, 4'b0000);
        chk("t6.nosel_ready", Hready_out, 1'b1);
        tick(); bus_idle(); settle();
        chk("t6.nosel_psel", Psel, 4'b0000);
        chk("t6.nosel_resp", Hresp, 1'b0);

        // Back-to-back write then read, then reset during a third ACCESS.
        tick(); addr_phase(32'h0000_1004, 1'b1, HSIZE_WORD); Pready = 4'b1111; settle();
        push(slv_word[1], 1'b0);
        tick(); Hwdata = 32'hCAFE_F00D; bus_idle(); settle();
        tick(); settle();
        chk("t7.setup_pwdata", Pwdata, 32'hCAFE_F00D);
        tick(); addr_phase(32'h0000_2008, 1'b0, HSIZE_WORD); settle();
        chk("t7.wr_pstrb", Pstrb, 4'b1111);
        sb_check("t7.wr");
        push(slv_word[2], 1'b0);
        tick(); bus_idle(); settle();
        chk("t7.rd_setup_psel", Psel, 4'b0100);
        chk("t7.rd_setup_penable", Penable, 1'b0);
        chk("t7.rd_setup_paddr", Paddr, 32'h0000_2008);
        tick(); addr_phase(32'h0000_3000, 1'b0, HSIZE_WORD); Pready = 4'b0111; settle();
        sb_check("t7.rd");
        push(slv_word[3], 1'b0);
        tick(); bus_idle(); settle();
        chk("t7.third_setup_psel", Psel, 4'b1000);
        tick(); settle();
        chk("t7.third_access_penable", Penable, 1'b1);
        chk("t7.third_access_ready", Hready_out, 1'b0);
        Hreset = 1'b1;
        sb.delete();
        tick(); Hreset = 1'b0; Pready = 4'b1111; settle();
        chk_reset("t7.rst");
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk("t7.post_rst_resp", Hresp, 1'b0);
            chk("t7.post_rst_penable", Penable, 1'b0);
        end
        chk("sb.empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
